bus_stream_fifo_device: RTL and testbench

- Memory-mapped responder (device end) for the 32-bit host/device bus used by the bus hubs.
- Bridges bus accesses to two streaming FIFOs:
  - bus writes to DATA push a TX FIFO, which drains to a valid/ready stream output;
  - a valid/ready stream input fills an RX FIFO, and bus reads of DATA pop it.
- Drives its own self-demux `bus_active` from the address, so it plugs directly into any hub device port.

---
 rtl/bus_stream_fifo_device.sv | 120 ++++++++++++
 tb/tb_bus_stream_fifo_device.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_stream_fifo_device.sv
// bus_stream_fifo_device: bus responder bridging DATA accesses to a TX and an RX stream FIFO.
module bus_stream_fifo_device #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_data_write,
    input  logic [3:0]  bus_write_mask,
    input  logic        bus_ren,
    input  logic        bus_wen,
    output logic [31:0] bus_data_read,
    output logic        bus_ready,
    output logic        bus_active,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, RESP} state_t;
    state_t state_q, state_d;

    logic [31:0]   tx_mem_q [DEPTH];
    logic [31:0]   rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    off;
    logic [31:0]   wdata, status;
    logic          acc, wr, rd, ctrl;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          tx_flush, rx_flush, tx_clr, rx_clr;

    // Shifts keep the ignored low address bits referenced without slicing them away.
    assign bus_active = (bus_address >> 4) == (BASE_ADDR >> 4);
    assign off        = 2'(bus_address >> 2);
    assign acc        = state_q == IDLE && bus_active && (bus_ren || bus_wen);
    assign wr         = acc && bus_wen;
    assign rd         = acc && bus_ren && !bus_wen;
    assign wdata      = bus_data_write & {{8{bus_write_mask[3]}}, {8{bus_write_mask[2]}},
                                          {8{bus_write_mask[1]}}, {8{bus_write_mask[0]}}};

    assign tx_full  = tx_cnt_q == CW'(DEPTH);
    assign tx_empty = tx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == CW'(DEPTH);
    assign rx_empty = rx_cnt_q == '0;

    assign tx_push  = wr && off == 2'd0 && !tx_full;
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = rd && off == 2'd0 && !rx_empty;

    assign ctrl     = wr && off == 2'd2 && bus_write_mask[0];
    assign tx_flush = ctrl && bus_data_write[0];
    assign rx_flush = ctrl && bus_data_write[1];
    assign tx_clr   = ctrl && bus_data_write[4];
    assign rx_clr   = ctrl && bus_data_write[5];

    assign status = {8'd0, 8'(rx_cnt_q), 8'(tx_cnt_q), 2'b00, rx_udf_q, tx_ovf_q,
                     rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        state_d  = acc ? RESP : IDLE;
        rdata_d  = !rd ? '0 :
                   off == 2'd0 ? (rx_empty ? '0 : rx_mem_q[rx_rp_q]) :
                   off == 2'd1 ? status : '0;
        tx_cnt_d = tx_flush ? '0 : tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_flush ? '0 : rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        tx_ovf_d = (wr && off == 2'd0 && tx_full) || (tx_ovf_q && !tx_clr);
        rx_udf_d = (rd && off == 2'd0 && rx_empty) || (rx_udf_q && !rx_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            tx_wp_q  <= tx_flush ? '0 : tx_wp_q + AW'(tx_push);
            tx_rp_q  <= tx_flush ? '0 : tx_rp_q + AW'(tx_pop);
            rx_wp_q  <= rx_flush ? '0 : rx_wp_q + AW'(rx_push);
            rx_rp_q  <= rx_flush ? '0 : rx_rp_q + AW'(rx_pop);
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= wdata;
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
    end

    assign bus_ready     = state_q == RESP;
    assign bus_data_read = bus_ready ? rdata_q : '0;
    assign tx_valid      = !tx_empty;
    assign tx_data       = tx_empty ? '0 : tx_mem_q[tx_rp_q];
    assign rx_ready      = !rx_full;
endmodule

// File: tb/tb_bus_stream_fifo_device.sv
// tb_bus_stream_fifo_device: queue-based reference model with scoreboarded bus responses and stream monitors.
module tb_bus_stream_fifo_device;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bus_address, bus_data_write, bus_data_read, tx_data, rx_data;
    logic [3:0]  bus_write_mask;
    logic        bus_ren, bus_wen, bus_ready, bus_active;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;

    bus_stream_fifo_device #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_address(bus_address), .bus_data_write(bus_data_write),
        .bus_write_mask(bus_write_mask), .bus_ren(bus_ren), .bus_wen(bus_wen),
        .bus_data_read(bus_data_read), .bus_ready(bus_ready), .bus_active(bus_active),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [31:0] txm[$], rxm[$], exp_q[$], rx_send_q[$];
    bit tx_ovf, rx_udf, tx_push_pend, rx_pop_pend, run, rx_rand, rx_fire;
    int tx_mode;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [31:0] status_m();
        int tc, rc;
        tc = txm.size();
        rc = rxm.size();
        return {8'd0, 8'(rc), 8'(tc), 2'b00, rx_udf, tx_ovf, rc == 0, rc == DEPTH, tc == 0, tc == DEPTH};
    endfunction

    function automatic void model_reset();
        txm.delete(); rxm.delete();
        tx_ovf = 0; rx_udf = 0; tx_push_pend = 0; rx_pop_pend = 0;
    endfunction

    // Called just after a posedge; returns just after the posedge that ends the response cycle.
    task automatic bus(input logic [31:0] addr, input bit r, input bit w, input logic [31:0] wd, input logic [3:0] m);
        logic [31:0] e, mx;
        logic [1:0]  off;
        bit hit;
        e   = '0;
        off = addr[3:2];
        hit = addr[31:4] == BASE[31:4];
        mx  = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        bus_address = addr; bus_ren = r; bus_wen = w; bus_data_write = wd; bus_write_mask = m;
        #1;
        chk("bus_active", {31'd0, bus_active}, {31'd0, hit});
        if (hit && (r || w)) begin
            if (w) begin
                if (off == 2'd0) begin
                    if (txm.size() < DEPTH) begin
                        txm.push_back(wd & mx);
                        tx_push_pend = 1;
                    end else tx_ovf = 1;
                end
            end else if (off == 2'd0) begin
                if (rxm.size() > 0) begin
                    e = rxm.pop_front();
                    rx_pop_pend = 1;
                end else rx_udf = 1;
            end else if (off == 2'd1) e = status_m();
            exp_q.push_back(e);
        end
        @(posedge clk);
        tx_push_pend = 0;
        rx_pop_pend  = 0;
        if (hit && w && off == 2'd2 && m[0]) begin
            if (wd[0]) txm.delete();
            if (wd[1]) rxm.delete();
            if (wd[4]) tx_ovf = 0;
            if (wd[5]) rx_udf = 0;
        end
        #1 bus_ren = 0; bus_wen = 0;
        @(posedge clk);
        #1;
        chk("ack_latency", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Stream driver and monitor: decides this cycle's handshakes, then predicts their effect.
    initial begin
        int pre;
        rx_valid = 0; rx_data = '0; tx_ready = 0; rx_fire = 0;
        forever begin
            @(negedge clk);
            if (run) begin
                if (rx_fire) rx_valid = 0;
                if (!rx_valid) begin
                    if (rx_send_q.size() > 0) begin
                        rx_valid = 1;
                        rx_data  = rx_send_q.pop_front();
                    end else if (rx_rand && $urandom_range(1) == 1) begin
                        rx_valid = 1;
                        rx_data  = $urandom;
                    end
                end
                tx_ready = tx_mode == 2 ? 1'($urandom_range(1)) : tx_mode == 1;
                pre = rxm.size() + int'(rx_pop_pend);
                chk("rx_ready", {31'd0, rx_ready}, {31'd0, pre < DEPTH});
                rx_fire = rx_valid && rx_ready;
                if (rx_fire) rxm.push_back(rx_data);
                pre = txm.size() - int'(tx_push_pend);
                chk("tx_valid", {31'd0, tx_valid}, {31'd0, pre > 0});
                if (tx_valid && tx_ready) begin
                    if (txm.size() == 0) chk("tx_pop_unexpected", tx_data, 32'hxxxx_xxxx);
                    else chk("tx_stream", tx_data, txm.pop_front());
                end else if (!tx_valid) chk("tx_data_empty", tx_data, '0);
            end
        end
    end

    // Bus response scoreboard.
    initial forever begin
        @(negedge clk);
        if (run) begin
            if (bus_ready) begin
                if (exp_q.size() == 0) chk("spurious_ready", bus_data_read, 32'hxxxx_xxxx);
                else chk("bus_rdata", bus_data_read, exp_q.pop_front());
            end else chk("rdata_idle", bus_data_read, '0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, wd;
        int k;
        rst_n = 0; bus_address = '0; bus_data_write = '0; bus_write_mask = '0;
        bus_ren = 0; bus_wen = 0; tx_mode = 0; rx_rand = 0; run = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_bus_ready", {31'd0, bus_ready}, '0);
        chk("rst_tx_valid", {31'd0, tx_valid}, '0);
        chk("rst_tx_data", tx_data, '0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        run = 1;

        bus(BASE, 0, 1, 32'hDEAD_BEEF, 4'hF);
        chk("tx_head", tx_data, 32'hDEAD_BEEF);
        bus(BASE + 4, 1, 0, '0, 4'h0);
        bus(BASE + 8, 0, 1, 32'h1, 4'h1);
        bus(BASE, 0, 1, 32'h1122_3344, 4'b0101);
        chk("tx_masked", tx_data, 32'h0022_0044);
        bus(BASE + 8, 0, 1, 32'h1, 4'h1);

        for (int i = 0; i < 3; i++) rx_send_q.push_back(32'hA000_0000 + i);
        for (int i = 0; i < 50 && rxm.size() < 3; i++) @(posedge clk);
        #1 chk("rx_fill", rxm.size(), 3);
        for (int i = 0; i < 4; i++) bus(BASE, 1, 0, '0, 4'h0);
        bus(BASE + 4, 1, 0, '0, 4'h0);
        bus(BASE + 8, 0, 1, 32'h20, 4'hF);
        bus(BASE + 4, 1, 0, '0, 4'h0);

        for (int i = 0; i <= DEPTH; i++) bus(BASE, 0, 1, 32'h5000_0000 + i, 4'hF);
        bus(BASE + 4, 1, 0, '0, 4'h0);
        tx_mode = 1;
        for (int i = 0; i < 100 && txm.size() > 0; i++) @(posedge clk);
        #1 chk("tx_drain", txm.size(), 0);
        bus(BASE + 8, 0, 1, 32'h10, 4'h1);

        for (int i = 0; i < 4; i++) begin
            bus(BASE, 0, 1, $urandom, 4'hF);
            bus(BASE + 4, 1, 0, '0, 4'h0);
        end

        rx_send_q.push_back(32'hB000_0001);
        for (int i = 0; i < 50 && rxm.size() < 1; i++) @(posedge clk);
        #1 rx_send_q.push_back(32'hB000_0002);
        bus(BASE, 1, 0, '0, 4'h0);
        bus(BASE + 4, 1, 0, '0, 4'h0);
        bus(BASE + 12, 1, 0, '0, 4'h0);
        bus(BASE + 12, 0, 1, 32'hFFFF_FFFF, 4'hF);
        bus(BASE + 16, 1, 0, '0, 4'h0);
        bus(BASE + 16, 0, 1, 32'h3, 4'hF);

        tx_mode = 2; rx_rand = 1;
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(9);
            a = BASE + 32'($urandom_range(3));
            wd = $urandom;
            case (k)
                0, 1, 2: bus(a, 0, 1, wd, 4'($urandom));
                3:       bus(a, 1, 1, wd, 4'hF);
                4, 5:    bus(a, 1, 0, wd, 4'h0);
                6:       bus(a + 4, 1, 0, wd, 4'h0);
                7:       bus(a + 8, 0, 1, ($urandom_range(3) == 0) ? wd & 32'h33 : wd & 32'h30, 4'($urandom));
                8:       bus(a + 4 * $urandom_range(1, 3), $urandom_range(1) == 1, 1, wd, 4'($urandom));
                default: bus(($urandom_range(1) == 1) ? a + 16 : a - 4, 1, 0, wd, 4'h0);
            endcase
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        tx_mode = 1; rx_rand = 0;
        for (int i = 0; i < 100 && txm.size() > 0; i++) @(posedge clk);
        #1 chk("final_tx_drain", txm.size(), 0);
        bus(BASE + 4, 1, 0, '0, 4'h0);

        tx_mode = 0;
        repeat (3) @(posedge clk);
        #1 bus(BASE, 0, 1, 32'h7777_7777, 4'hF);
        rx_send_q.push_back(32'hC000_0000);
        repeat (4) @(posedge clk);
        #1 bus_address = BASE + 4; bus_ren = 1;
        exp_q.push_back(status_m());
        @(posedge clk);
        #1 rst_n = 0; bus_ren = 0;
        @(posedge clk);
        model_reset();
        #1;
        chk("rst_resp_ready", {31'd0, bus_ready}, '0);
        chk("rst_resp_tx_valid", {31'd0, tx_valid}, '0);
        chk("rst_resp_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_resp_ack", exp_q.size(), 0);
        rst_n = 1;
        bus(BASE + 4, 1, 0, '0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
